// File: rtl/softmax_pkg.sv
// Shared widths and element types for the softmax datapath.
package softmax_pkg;

  localparam int DATA_W      = 32;
  localparam int VEC_LEN_DEF = 32;
  localparam int IDX_W       = $clog2(VEC_LEN_DEF);

  typedef logic [DATA_W-1:0] elem_t;
  typedef logic [IDX_W-1:0]  idx_t;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus framed valid/ready stream between the FIFO reader and the next softmax stage.
interface fifo_reader_if
  import softmax_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int IW = IDX_W
) ();

  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [IW-1:0] m_idx;
  logic          vec_done;

  // Reader side: drives the FIFO read request and the outgoing stream.
  modport master (
    output fifo_rd_en,
    input  fifo_data_out,
    input  fifo_empty,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last,
    output m_idx,
    output vec_done
  );

  // Environment side: the FIFO and the downstream consumer.
  modport slave (
    input  fifo_rd_en,
    output fifo_data_out,
    output fifo_empty,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last,
    input  m_idx,
    input  vec_done
  );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry ring buffer that absorbs the FIFO read latency; clear drops all contents.
module skid_buf2
  import softmax_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    occ
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  // A pop on an empty buffer or a push into a full one is ignored so the pointers never desync.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && (count != 2'd2);

  assign head = mem[rd_ptr];
  assign occ  = count;

  // Storage, pointers and occupancy; a same-cycle push and pop keeps occupancy while the head advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Drains the softmax datapath FIFO into a valid/ready stream framed into vectors of VEC_LEN elements.
module fifo_reader
  import softmax_pkg::*;
#(
  parameter int DW      = DATA_W,
  parameter int VEC_LEN = VEC_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  fifo_reader_if.master bus
);

  localparam int            IW       = $clog2(VEC_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(VEC_LEN - 1);

  logic [1:0]    occ;
  logic          inflight;
  logic          pop;
  logic          rd_en;
  logic [2:0]    pending;
  logic [DW-1:0] head;
  logic [IW-1:0] idx;
  logic          vec_done_q;

  // Elements already held or on their way, after this cycle's pop; a read is only issued if it will fit.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // A handshake during flush is ignored so the discarded vector cannot advance the framing.
  assign pop   = bus.m_valid && bus.m_ready && !flush;
  assign rd_en = !bus.fifo_empty && !flush && (pending < 3'd2);

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != 2'd0);
  assign bus.m_data     = head;
  assign bus.m_idx      = idx;
  assign bus.m_last     = (idx == LAST_IDX);
  assign bus.vec_done   = vec_done_q;

  skid_buf2 #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (inflight),
    .push_data (bus.fifo_data_out),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  // Marks the cycle in which the FIFO presents the data of last cycle's read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else if (flush) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
    end
  end

  // Position within the vector and the one-cycle pulse after the last element is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      vec_done_q <= 1'b0;
    end else if (flush) begin
      idx        <= '0;
      vec_done_q <= 1'b0;
    end else begin
      vec_done_q <= pop && (idx == LAST_IDX);
      if (pop) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader with VEC_LEN=4, a behavioural FIFO and a scoreboard monitor.
module tb_fifo_reader;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        m_ready;
  logic        fifo_empty_r = 1'b1;
  logic [31:0] fifo_data_r  = '0;

  int          n_tests = 0;
  int          n_fails = 0;
  int          exp_idx = 0;
  int          taken   = 0;
  bit          wr_done = 1'b0;
  logic        done_due = 1'b0;
  exp_t        mon_e;

  logic [31:0] stim_q [$];
  logic [31:0] fifo_q [$];
  exp_t        exp_q  [$];

  fifo_reader_if #(.DW(32), .IW(2)) bus ();

  assign bus.fifo_empty    = fifo_empty_r;
  assign bus.fifo_data_out = fifo_data_r;
  assign bus.m_ready       = m_ready;

  fifo_reader #(.DW(32), .VEC_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Writes one element into the FIFO and records what the stream must later show for it.
  task automatic applyStimulus(input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.idx  = exp_idx[1:0];
    e.last = (exp_idx == 3);
    stim_q.push_back(d);
    exp_q.push_back(e);
    exp_idx = (exp_idx == 3) ? 0 : exp_idx + 1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flushIdle();
    m_ready = 1'b0;
    flush   = 1'b1;
    waitCycles(1);
    flush   = 1'b0;
    exp_idx = 0;
    checkOutput("flush_idle_idx", {30'b0, bus.m_idx}, 32'd0);
    waitCycles(1);
  endtask

  // Behavioural FIFO: registered read data held between reads, writes visible from the next cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      taken = stim_q.size();
      fifo_empty_r <= 1'b1;
      fifo_data_r  <= '0;
    end else begin
      if (bus.fifo_rd_en) begin
        checkOutput("rd_en_while_empty", {31'b0, fifo_empty_r}, 32'd0);
        if (fifo_q.size() != 0) fifo_data_r <= fifo_q.pop_front();
      end
      while (taken < stim_q.size()) begin
        fifo_q.push_back(stim_q[taken]);
        taken++;
      end
      fifo_empty_r <= (fifo_q.size() == 0);
    end
  end

  // Scoreboard monitor: every accepted element is compared against the next expected entry.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      done_due = 1'b0;
    end else begin
      checkOutput("vec_done", {31'b0, bus.vec_done}, {31'b0, done_due});
      done_due = 1'b0;
      if (flush) begin
        exp_q.delete();
      end else if (bus.m_valid && m_ready) begin
        checkOutput("element_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("sb_data", bus.m_data, mon_e.data);
          checkOutput("sb_idx", {30'b0, bus.m_idx}, {30'b0, mon_e.idx});
          checkOutput("sb_last", {31'b0, bus.m_last}, {31'b0, mon_e.last});
          done_due = mon_e.last;
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    waitCycles(2);
    checkOutput("reset_valid", {31'b0, bus.m_valid}, 32'd0);
    checkOutput("reset_data", bus.m_data, 32'd0);
    checkOutput("reset_last", {31'b0, bus.m_last}, 32'd0);
    checkOutput("reset_idx", {30'b0, bus.m_idx}, 32'd0);
    checkOutput("reset_vec_done", {31'b0, bus.vec_done}, 32'd0);
    checkOutput("reset_rd_en", {31'b0, bus.fifo_rd_en}, 32'd0);
    rst_n = 1'b1;
    waitCycles(2);

    // Single element: read issued the cycle the FIFO goes non-empty, output two cycles later.
    m_ready = 1'b1;
    applyStimulus(32'hA5);
    waitCycles(1);
    checkOutput("single_rd_en_on", {31'b0, bus.fifo_rd_en}, 32'd1);
    waitCycles(1);
    checkOutput("single_rd_en_off", {31'b0, bus.fifo_rd_en}, 32'd0);
    checkOutput("single_not_yet_valid", {31'b0, bus.m_valid}, 32'd0);
    waitCycles(1);
    checkOutput("single_valid", {31'b0, bus.m_valid}, 32'd1);
    checkOutput("single_data", bus.m_data, 32'hA5);
    checkOutput("single_idx", {30'b0, bus.m_idx}, 32'd0);
    checkOutput("single_last", {31'b0, bus.m_last}, 32'd0);
    waitCycles(1);
    checkOutput("single_no_vec_done", {31'b0, bus.vec_done}, 32'd0);
    checkOutput("single_drained", {31'b0, bus.m_valid}, 32'd0);
    flushIdle();

    // Two full vectors back to back without bubbles.
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) applyStimulus(i);
    waitCycles(3);
    for (int k = 0; k < 8; k++) begin
      checkOutput("burst_no_bubble", {31'b0, bus.m_valid}, 32'd1);
      waitCycles(1);
    end
    checkOutput("burst_end", {31'b0, bus.m_valid}, 32'd0);
    flushIdle();

    // Downstream stall on element 2 for five cycles.
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) applyStimulus(i);
    waitCycles(4);
    m_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_valid", {31'b0, bus.m_valid}, 32'd1);
      checkOutput("stall_data", bus.m_data, 32'd2);
      checkOutput("stall_idx", {30'b0, bus.m_idx}, 32'd1);
      checkOutput("stall_rd_en", {31'b0, bus.fifo_rd_en}, 32'd0);
      waitCycles(1);
    end
    m_ready = 1'b1;
    waitCycles(20);
    checkOutput("stall_drain", exp_q.size(), 32'd0);
    flushIdle();

    // Flush with one element buffered and one in flight; both must vanish.
    m_ready = 1'b0;
    applyStimulus(32'h11);
    applyStimulus(32'h22);
    waitCycles(3);
    checkOutput("flush_pre_valid", {31'b0, bus.m_valid}, 32'd1);
    flush = 1'b1;
    waitCycles(1);
    flush   = 1'b0;
    exp_idx = 0;
    checkOutput("flush_valid", {31'b0, bus.m_valid}, 32'd0);
    checkOutput("flush_idx", {30'b0, bus.m_idx}, 32'd0);
    checkOutput("flush_vec_done", {31'b0, bus.vec_done}, 32'd0);
    waitCycles(1);
    checkOutput("flush_no_stale", {31'b0, bus.m_valid}, 32'd0);
    m_ready = 1'b1;
    applyStimulus(32'h33);
    waitCycles(3);
    checkOutput("flush_next_valid", {31'b0, bus.m_valid}, 32'd1);
    checkOutput("flush_next_data", bus.m_data, 32'h33);
    checkOutput("flush_next_idx", {30'b0, bus.m_idx}, 32'd0);
    waitCycles(2);
    checkOutput("flush_drain", exp_q.size(), 32'd0);
    flushIdle();

    // Random writes and random downstream readiness over 1000 elements.
    wr_done = 1'b0;
    fork
      begin
        int n;
        n = 0;
        while (n < 1000) begin
          @(posedge clk);
          #1;
          if ($urandom_range(1, 0) == 1) begin
            applyStimulus($urandom);
            n++;
          end
        end
        wr_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(wr_done && exp_q.size() == 0) && cyc < 20000) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(1, 0) == 1);
          cyc++;
        end
      end
    join
    checkOutput("random_drain", exp_q.size(), 32'd0);
    flushIdle();

    // Asynchronous reset in the middle of a vector.
    m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) applyStimulus(32'h100 + i);
    waitCycles(5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", {31'b0, bus.m_valid}, 32'd0);
    checkOutput("areset_data", bus.m_data, 32'd0);
    checkOutput("areset_last", {31'b0, bus.m_last}, 32'd0);
    checkOutput("areset_idx", {30'b0, bus.m_idx}, 32'd0);
    checkOutput("areset_vec_done", {31'b0, bus.vec_done}, 32'd0);
    checkOutput("areset_rd_en", {31'b0, bus.fifo_rd_en}, 32'd0);
    exp_idx = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    waitCycles(1);
    applyStimulus(32'h55);
    waitCycles(3);
    checkOutput("after_reset_valid", {31'b0, bus.m_valid}, 32'd1);
    checkOutput("after_reset_data", bus.m_data, 32'h55);
    checkOutput("after_reset_idx", {30'b0, bus.m_idx}, 32'd0);
    waitCycles(2);
    checkOutput("after_reset_drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
